tcdm_master_arbiter: RTL
========================

Name: tcdm_master_arbiter

Overview:
- Shares one TCDM interconnect master port (req/add/wen/wdata/be/gnt/rvld/rdata) between NumReq local requesters, e.g. a core plus DMA and accelerator ports on one logarithmic or butterfly interconnect input.
- Round-robin arbitration, with the selection locked while the interconnect withholds grant.
- Tracks each granted access through the fixed response latency and routes rvld back to the issuing requester.
- Flags any response that arrives out of step with the tracked latency.

Parameters:
- NumReq, 4, number of local requesters; must be >=2.
- AddrWidth, 32, address width.
- DataWidth, 32, data word width.
- BeWidth, DataWidth/8, byte-enable width.
- RespLat, 1, cycles from master-side handshake to mst_rvld_i; must be >=1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NumReq  requester request
- add_i  in  NumReq x AddrWidth  requester address
- wen_i  in  NumReq  1=load, 0=store
- wdata_i  in  NumReq x DataWidth  write data
- be_i  in  NumReq x BeWidth  byte enables
- gnt_o  out  NumReq  grant, combinational
- rvld_o  out  NumReq  response valid, one-hot or zero
- rdata_o  out  NumReq x DataWidth  read data, mst_rdata_i broadcast to all
- mst_req_o  out  1  request to interconnect
- mst_add_o  out  AddrWidth  selected address
- mst_wen_o  out  1  selected wen
- mst_wdata_o  out  DataWidth  selected wdata
- mst_be_o  out  BeWidth  selected be
- mst_gnt_i  in  1  interconnect grant
- mst_rvld_i  in  1  interconnect response valid
- mst_rdata_i  in  DataWidth  interconnect read data
- busy_o  out  1  at least one access in flight in the response pipeline
- err_o  out  1  sticky response-mismatch flag
- stall_cnt_o  out  32  stall counter (optional feature)
- stall_clr_i  in  1  synchronous counter clear (optional feature)

Behaviour:
- Reset state: rr_q=0, lock_q=0, sel_q=0, all vld_q=0, err_o=0, stall counter=0.
- Reset output values, with req_i=0: gnt_o=0, rvld_o=0, mst_req_o=0, busy_o=0.
- Reset mid-operation discards in-flight tracking. No rvld_o is produced for accesses granted before reset.
- Selection:
  - If lock_q=1, sel = sel_q.
  - Otherwise sel = the first index i with req_i[i]=1, scanning from rr_q upward with wrap modulo NumReq.
- mst_req_o = |req_i. mst_add/wen/wdata/be = the fields of requester sel, muxed combinationally.
- gnt_o[sel] = mst_gnt_i & mst_req_o. All other gnt_o bits are 0. Path is combinational with 0-cycle latency.
- Handshake = mst_req_o & mst_gnt_i. On a handshake:
  - rr_q <= (sel+1) mod NumReq.
  - lock_q <= 0.
- Stall = mst_req_o & ~mst_gnt_i. On a stall:
  - lock_q <= 1, sel_q <= sel.
  - A later-arriving higher-priority requester must not displace the presented request.
- Requesters obey the TCDM rule: hold req and all fields until gnt. If the locked requester drops req_i anyway, lock_q clears in the next cycle and arbitration resumes from rr_q. A request is never dropped silently in that cycle; mst_req_o follows |req_i.
- Response pipeline: RespLat stages of {vld, id}.
  - Stage 0 loads {handshake, sel}. Each stage shifts every cycle.
  - rvld_o[id_last] = vld_last.
  - Loads and stores both return rvld, as the interconnect does.
- busy_o = OR of all vld stages.
- Back-to-back handshakes every cycle are supported, giving full throughput with no bubbles.
- Mismatch: if mst_rvld_i != vld_last in any cycle, err_o <= 1. err_o is sticky until reset. rvld_o is still driven from vld_last.

Optional Feature:
- Macro: TCDM_MASTER_ARBITER_STALL_CNT_EN.
- Defined:
  - stall_cnt_o increments by 1 on every stall cycle and saturates at 2^32-1.
  - stall_clr_i=1 resets it to 0. Clear takes priority over increment.
  - Reset value is 0.
- Undefined:
  - stall_cnt_o is tied to 0 and stall_clr_i is ignored.
  - No counter flops are present.

Test Plan:
- RR fairness: NumReq=4, req_i=4'b1111, mst_gnt_i=1 constant -> grants in order 0,1,2,3,0 on consecutive cycles; rvld_o one-hot 1,2,4,8 delayed by RespLat=1.
- Lock: req_i=4'b0100 with mst_gnt_i=0 for 3 cycles, req_i[0] raised at cycle 1, mst_gnt_i=1 at cycle 3 -> gnt_o=4'b0100 at cycle 3; gnt_o=4'b0001 at cycle 4.
- Latency: RespLat=3, single load from requester 2 with mst_rdata_i=32'hDEADBEEF -> rvld_o=4'b0100 exactly 3 cycles after handshake; rdata_o[2]=32'hDEADBEEF; busy_o high for those 3 cycles.
- Mismatch: inject mst_rvld_i=1 with no access in flight -> err_o=1 next cycle and stays 1 until rst_ni low.
- Reset mid-flight: RespLat=2, handshake then rst_ni low 1 cycle later -> rvld_o stays 0, busy_o=0, rr_q=0; the first post-reset grant goes to the lowest requesting index.
- Stall counter (macro defined): 5 stall cycles, then stall_clr_i asserted in the same cycle as a 6th stall -> stall_cnt_o reads 5, then 0.

Source files
------------

// File: rtl/tcdm_master_arbiter.sv
// Round-robin arbiter sharing one TCDM master port among NumReq requesters, with response routing.
// Optional stall counter enabled by defining TCDM_MASTER_ARBITER_STALL_CNT_EN.
module tcdm_master_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned BeWidth   = DataWidth / 8,
  parameter int unsigned RespLat   = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    add_i,
  input  logic [NumReq-1:0]                   wen_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]      be_i,
  output logic [NumReq-1:0]                   gnt_o,
  output logic [NumReq-1:0]                   rvld_o,
  output logic [NumReq-1:0][DataWidth-1:0]    rdata_o,
  output logic                                mst_req_o,
  output logic [AddrWidth-1:0]                mst_add_o,
  output logic                                mst_wen_o,
  output logic [DataWidth-1:0]                mst_wdata_o,
  output logic [BeWidth-1:0]                  mst_be_o,
  input  logic                                mst_gnt_i,
  input  logic                                mst_rvld_i,
  input  logic [DataWidth-1:0]                mst_rdata_i,
  output logic                                busy_o,
  output logic                                err_o,
  output logic [31:0]                         stall_cnt_o,
  input  logic                                stall_clr_i
);

  localparam int unsigned IdWidth = $clog2(NumReq);
  typedef logic [IdWidth-1:0] id_t;

  id_t                r_rr;
  id_t                r_sel;
  logic               r_lock;
  logic [RespLat-1:0] r_vld;
  id_t                r_id [RespLat];
  logic               r_err;

  id_t  w_scan;
  id_t  w_sel;
  id_t  w_rr_nxt;
  logic w_found;
  logic w_hs;
  logic w_stall;

  always_comb begin
    w_scan  = r_rr;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!w_found && req_i[id_t'((32'(r_rr) + k) % NumReq)]) begin
        w_scan  = id_t'((32'(r_rr) + k) % NumReq);
        w_found = 1'b1;
      end
    end
  end

  // A stalled request keeps its slot so the presented fields never change under the interconnect.
  assign w_sel    = r_lock ? r_sel : w_scan;
  assign w_rr_nxt = (w_sel == id_t'(NumReq - 1)) ? '0 : w_sel + id_t'(1);

  assign mst_req_o   = |req_i;
  assign w_hs        = mst_req_o & mst_gnt_i;
  assign w_stall     = mst_req_o & ~mst_gnt_i;
  assign mst_add_o   = add_i[w_sel];
  assign mst_wen_o   = wen_i[w_sel];
  assign mst_wdata_o = wdata_i[w_sel];
  assign mst_be_o    = be_i[w_sel];
  assign rdata_o     = {NumReq{mst_rdata_i}};

  always_comb begin
    gnt_o        = '0;
    gnt_o[w_sel] = w_hs;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr   <= '0;
      r_sel  <= '0;
      r_lock <= 1'b0;
    end else if (w_hs) begin
      r_rr   <= w_rr_nxt;
      r_lock <= 1'b0;
    end else if (w_stall && req_i[w_sel]) begin
      r_lock <= 1'b1;
      r_sel  <= w_sel;
    end else begin
      r_lock <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld <= '0;
      for (int i = 0; i < RespLat; i++) r_id[i] <= '0;
    end else begin
      r_vld[0] <= w_hs;
      r_id[0]  <= w_sel;
      for (int i = 1; i < RespLat; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end

  always_comb begin
    rvld_o = '0;
    if (r_vld[RespLat-1]) rvld_o[r_id[RespLat-1]] = 1'b1;
  end

  assign busy_o = |r_vld;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (mst_rvld_i != r_vld[RespLat-1]) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;

`ifdef TCDM_MASTER_ARBITER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (stall_clr_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = stall_clr_i;
  assign stall_cnt_o  = '0;
`endif

endmodule
